// File: rtl/gerador_paridade_par_tx.sv
// gerador_paridade_par_tx: LSB-first serial transmitter that appends an even-parity bit per word.
// Optional START_BIT_EN macro inserts a 0 start bit (not counted in the parity) before the data bits.
module gerador_paridade_par_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              frame_end
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
`ifdef START_BIT_EN
  localparam state_t FIRST = START;
`else
  localparam state_t FIRST = DATA;
`endif
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              par;
  assign ready     = (state == IDLE) || (state == PARITY);
  assign out_valid = (state != IDLE);
  assign frame_end = (state == PARITY);
  assign out_bit   = (state == DATA) ? shreg[0] : (state == PARITY) ? par : 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (in_valid && ready) begin
      state <= FIRST;
      shreg <= data_in;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        START:  state <= DATA;
        DATA: begin
          shreg <= shreg >> 1;
          par   <= par ^ shreg[0];
          cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
          state <= (cnt == LAST) ? PARITY : DATA;
        end
        PARITY: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
